// File: rtl/sprite_anim_sequencer.sv
// Sprite strip animation sequencer plus the registered per-pixel sprite ROM address.
// Optional build macro SPRITE_MIRROR_EN adds a per-pixel horizontal mirror input.
module sprite_anim_sequencer #(
    parameter int unsigned SPR_W       = 50,
    parameter int unsigned SPR_H       = 64,
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned FRAME_TICKS = 8,
    parameter int unsigned ADDR_W      = 14,
    localparam int unsigned FIW        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_start,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
`ifdef SPRITE_MIRROR_EN
    input  logic              mirror,
`endif
    output logic              busy,
    output logic              done,
    output logic [FIW-1:0]    frame_idx,
    output logic [ADDR_W-1:0] rom_address,
    output logic              in_sprite
);

    localparam int unsigned TW         = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TW-1:0]  TICK_LAST  = TW'(FRAME_TICKS - 1);
    localparam logic [FIW-1:0] FRAME_LAST = FIW'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StPlay, StHold} state_e;

    state_e         state_q, state_d;
    logic [FIW-1:0] frame_q, frame_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic           done_q, done_d;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= StIdle;
            frame_q <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = StIdle;
            frame_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    frame_d = '0;
                    tick_d  = '0;
                    if (start) state_d = StArmed;
                end
                // frame_idx keeps its old value until playback actually begins
                StArmed: begin
                    if (frame_start) begin
                        state_d = StPlay;
                        frame_d = '0;
                        tick_d  = '0;
                    end
                end
                StPlay: begin
                    if (frame_start) begin
                        if (tick_q != TICK_LAST) begin
                            tick_d = tick_q + 1'b1;
                        end else begin
                            tick_d = '0;
                            if (frame_q != FRAME_LAST) begin
                                frame_d = frame_q + 1'b1;
                            end else if (loop) begin
                                frame_d = '0;
                            end else begin
                                state_d = StHold;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                StHold: begin
                    if (start) state_d = StArmed;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == StArmed) || (state_q == StPlay);
        done      = done_q;
        frame_idx = frame_q;
    end

    logic [9:0]        dx, dy;
    logic [10:0]       x_end, y_end;
    logic              hit;
    logic [ADDR_W-1:0] col, addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              in_q;

    // 11-bit bounds so a sprite near the right/bottom edge never wraps to column 0
    always_comb begin
        dx    = DrawX - pos_x;
        dy    = DrawY - pos_y;
        x_end = {1'b0, pos_x} + 11'(SPR_W);
        y_end = {1'b0, pos_y} + 11'(SPR_H);
        hit   = (DrawX >= pos_x) && ({1'b0, DrawX} < x_end) &&
                (DrawY >= pos_y) && ({1'b0, DrawY} < y_end);
        col   = ADDR_W'(dx);
`ifdef SPRITE_MIRROR_EN
        if (mirror) col = ADDR_W'(SPR_W - 1) - ADDR_W'(dx);
`endif
        addr_d = '0;
        if (hit) begin
            addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(dy) * ADDR_W'(SPR_W) + col;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            addr_q <= '0;
            in_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            in_q   <= hit;
        end
    end

    assign rom_address = addr_q;
    assign in_sprite   = in_q;

endmodule

// File: doc/sprite_anim_sequencer.md
# sprite_anim_sequencer

Animation controller for the palettized 50x64 sprite ROMs. It steps a multi-frame sprite strip (for example a death animation) through its frames at a programmable rate. Frame changes occur only at video-frame boundaries. It also computes the per-pixel ROM address for a sprite placed at (pos_x, pos_y), together with an aligned in-sprite flag. It sits between the game-logic FSM (start/stop/loop requests) and the sprite ROM/palette pair inside the VGA pixel pipeline.

## Interface
Parameters:
- SPR_W, 50, sprite width in pixels
- SPR_H, 64, sprite height in pixels
- NUM_FRAMES, 4, frames stored back-to-back in the ROM, frame-major
- FRAME_TICKS, 8, video frames each animation frame is displayed (≥1)
- ADDR_W, 14, ROM address width (≥ clog2(NUM_FRAMES*SPR_W*SPR_H))

Ports:
- vga_clk  in  1  pixel clock; all state on posedge
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- frame_start  in  1  one-cycle pulse, once per video frame (start of vertical blank)
- start  in  1  one-cycle request to arm playback
- stop  in  1  one-cycle abort
- loop  in  1  level; 1 = wrap to frame 0 after last frame
- pos_x  in  10  sprite left column
- pos_y  in  10  sprite top row
- busy  out  1  high in ARMED and PLAY
- done  out  1  one-cycle pulse on entering HOLD
- frame_idx  out  clog2(NUM_FRAMES)  current animation frame
- rom_address  out  ADDR_W  registered ROM address
- in_sprite  out  1  registered; current pixel lies inside the sprite box

## Operation
FSM states: IDLE, ARMED, PLAY, HOLD.
- **IDLE:**
  - frame_idx=0, tick=0.
  - start → ARMED.
- **ARMED:**
  - frame_idx holds its previous value.
  - frame_start → PLAY with frame_idx=0, tick=0.
- **PLAY:** on frame_start:
  - If tick<FRAME_TICKS-1: tick+1.
  - Else tick=0, and then:
    - if frame_idx<NUM_FRAMES-1: frame_idx+1;
    - else if loop=1: frame_idx=0;
    - else → HOLD, done=1 for one cycle.
  - loop is sampled only at this wrap point.
- **HOLD:**
  - Last frame is displayed; busy=0.
  - start → ARMED.
- **start:** ignored in ARMED and PLAY.
- **stop:** forces IDLE (frame_idx=0, tick=0, busy=0) from any state on the next edge. It wins over start and over frame_start in the same cycle. No done pulse is generated.
- **Pixel path:**
  - dx = DrawX−pos_x, dy = DrawY−pos_y, computed as unsigned 10-bit values.
  - hit = DrawX≥pos_x && DrawX<pos_x+SPR_W && DrawY≥pos_y && DrawY<pos_y+SPR_H. The comparisons use 11-bit sums so that pos+SPR does not wrap.
  - On hit: rom_address = frame_idx*SPR_W*SPR_H + dy*SPR_W + dx.
  - On no hit: rom_address = 0 and in_sprite = 0.
  - Products are computed at ADDR_W width.

## Timing
- Reset values:
  - state=IDLE
  - frame_idx=0, tick=0
  - busy=0, done=0
  - rom_address=0, in_sprite=0
- rom_address and in_sprite are registered one posedge after DrawX/DrawY. The ROM then samples on the following negedge, and the palette output is registered by the pixel stage at the next posedge.
- The frame_idx used for addressing changes only on the cycle after frame_start, so there is no tearing inside the visible area.
- busy rises on the edge that samples start. done is high for exactly one cycle, and on that same edge busy falls.
- Reset asserted mid-playback returns every output to its reset value on the next edge.

## Configuration
- SPRITE_MIRROR_EN defined:
  - Adds input port mirror (1 bit, level).
  - When mirror=1 on a hit, the column term becomes SPR_W−1−dx.
  - mirror is sampled on the same edge as DrawX, so flipping is per pixel and immediate.
- Not defined:
  - The mirror port is absent and the column term is always dx.

## Test plan
- **Reset:** assert reset for 2 cycles mid-PLAY → all outputs 0 and state IDLE on the first reset edge.
- **One-shot playback:** NUM_FRAMES=4, FRAME_TICKS=2, loop=0; pulse start, then 9 frame_start pulses → frame_idx sequence 0,0,1,1,2,2,3,3, then done pulses once after pulse 9; busy=0 in HOLD with frame_idx=3.
- **Loop:** same as one-shot with loop=1 → after frame_idx=3 for 2 ticks, frame_idx=0; done never asserts.
- **Addressing:** pos=(100,200), frame_idx=2.
  - DrawX=100, DrawY=200 → rom_address=6400 and in_sprite=1, one cycle later.
  - DrawX=149, DrawY=263 → rom_address=9599.
  - DrawX=150 → in_sprite=0 and rom_address=0.
- **Edge priority:**
  - stop and start in the same cycle during PLAY → IDLE, frame_idx=0.
  - start in PLAY → ignored.
  - pos_x=620 with DrawX=639 → hit without wrap; DrawX=0 → no hit.
- **Mirror (SPRITE_MIRROR_EN):** pos=(0,0), frame 0, mirror=1, DrawX=0, DrawY=0 → rom_address=49; mirror=0 → 0.
